// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_padder
// Purpose  : Packs a byte stream into FIPS 180-4 padded 512-bit SHA-256 blocks.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t             state_q;
    logic [511:0]       data_q;
    logic [6:0]         byte_cnt_q;
    logic [LEN_W-1:0]   bit_len_q;
    logic               pend_extra_q;
    logic               extra_marker_q;
    logic               blk_last_q;
    logic               blk_valid_q;
    logic               in_ready_q;

    logic [6:0]         w_cnt_inc;
    logic [LEN_W-1:0]   w_len_inc;
    logic [63:0]        w_len_fld_inc;
    logic [63:0]        w_len_fld;
    logic [511:0]       data_d;
    logic               w_accept;

    assign w_accept      = in_valid && in_ready_q;
    assign w_cnt_inc     = byte_cnt_q + 7'd1;
    assign w_len_inc     = bit_len_q + LEN_W'(8);
    assign w_len_fld_inc = 64'(w_len_inc);
    assign w_len_fld     = 64'(bit_len_q);

    // Buffer is cleared at every message/block start, so only non-zero bytes
    // need writing here; byte k lives at bits [511-8k -: 8] == [(63-k)*8 +: 8].
    always_comb begin
        data_d = data_q;
        data_d[{~byte_cnt_q[5:0], 3'b000} +: 8] = in_data;
        if (in_last) begin
            if (w_cnt_inc <= 7'd55) begin
                data_d[{~w_cnt_inc[5:0], 3'b000} +: 8] = 8'h80;
                data_d[63:0] = w_len_fld_inc;
            end else if (w_cnt_inc <= 7'd63) begin
                data_d[{~w_cnt_inc[5:0], 3'b000} +: 8] = 8'h80;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_FILL;
            data_q         <= '0;
            byte_cnt_q     <= '0;
            bit_len_q      <= '0;
            pend_extra_q   <= 1'b0;
            extra_marker_q <= 1'b0;
            blk_last_q     <= 1'b0;
            blk_valid_q    <= 1'b0;
            in_ready_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    in_ready_q <= 1'b1;
                    if (w_accept) begin
                        data_q    <= data_d;
                        bit_len_q <= w_len_inc;
                        if (in_last) begin
                            byte_cnt_q  <= w_cnt_inc;
                            state_q     <= ST_EMIT;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            if (w_cnt_inc <= 7'd55) begin
                                blk_last_q <= 1'b1;
                            end else begin
                                blk_last_q     <= 1'b0;
                                pend_extra_q   <= 1'b1;
                                extra_marker_q <= (w_cnt_inc == 7'd64);
                            end
                        end else if (w_cnt_inc == 7'd64) begin
                            byte_cnt_q  <= '0;
                            state_q     <= ST_EMIT;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            blk_last_q  <= 1'b0;
                        end else begin
                            byte_cnt_q <= w_cnt_inc;
                        end
                    end
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        if (pend_extra_q) begin
                            // Back-to-back length-only block, no idle cycle.
                            data_q       <= {(extra_marker_q ? 8'h80 : 8'h00), 440'd0, w_len_fld};
                            blk_last_q   <= 1'b1;
                            pend_extra_q <= 1'b0;
                        end else begin
                            if (blk_last_q) begin
                                bit_len_q  <= '0;
                                byte_cnt_q <= '0;
                            end
                            data_q      <= '0;
                            blk_last_q  <= 1'b0;
                            blk_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_FILL;
                        end
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = data_q;
    assign blk_last  = blk_last_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_padder
// Purpose  : Randomized self-checking bench against a byte-queue padding model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    int n_cmp = 0;
    int n_err = 0;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: message ++ 0x80 ++ zeros to 56 mod 64 ++ 64-bit big-endian bit count.
    task automatic run_msg(input logic [7:0] msg[$], input int mode);
        logic [7:0]   pad[$];
        logic [511:0] exp_q[$];
        logic         exp_last[$];
        logic [511:0] blk;
        logic [63:0]  bits;
        int n, nb, idx, got, vcyc, hold, cyc;
        n    = msg.size();
        pad  = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bits = 64'(n) * 64'd8;
        for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
        nb = pad.size() / 64;
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = pad[64*b+k];
            exp_q.push_back(blk);
            exp_last.push_back(b == nb - 1);
        end

        idx = 0; got = 0; vcyc = 0; hold = 0; cyc = 0;
        while (got < nb && cyc < 4000) begin
            if (blk_valid) begin
                vcyc++;
                hold++;
                check_val("blk_data", blk_data, exp_q[got]);
                check_val("blk_last", 512'(blk_last), 512'(exp_last[got]));
                check_val("in_ready_in_emit", 512'(in_ready), 512'd0);
            end
            case (mode)
                0: begin
                    blk_ready = 1'b1;
                    in_valid  = (idx < n);
                end
                1: begin
                    blk_ready = (hold > 5);
                    in_valid  = (idx < n);
                end
                default: begin
                    blk_ready = 1'($urandom % 2);
                    in_valid  = (idx < n) && ($urandom % 4 != 0);
                end
            endcase
            if (in_valid) begin
                in_data = msg[idx];
                in_last = (idx == n - 1);
            end else begin
                in_data = 8'($urandom);
                in_last = 1'($urandom);
            end
            if (in_valid && in_ready) idx++;
            if (blk_valid && blk_ready) begin
                got++;
                hold = 0;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        check_val("block_count", 512'(got), 512'(nb));
        check_val("bytes_taken", 512'(idx), 512'(n));
        if (mode == 0) check_val("valid_cycles", 512'(vcyc), 512'(nb));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m[$];
        int acc;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 512'(in_ready), 512'd0);
        check_val("rst_blk_valid", 512'(blk_valid), 512'd0);
        check_val("rst_blk_last", 512'(blk_last), 512'd0);
        check_val("rst_blk_data", blk_data, 512'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rel_in_ready", 512'(in_ready), 512'd1);

        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 0);

        m = {}; for (int i = 0; i < 55; i++) m.push_back(8'h00);
        run_msg(m, 0);
        m = {}; for (int i = 0; i < 56; i++) m.push_back(8'h00);
        run_msg(m, 0);
        m = {}; for (int i = 0; i < 64; i++) m.push_back(8'(i));
        run_msg(m, 0);
        m = {}; for (int i = 0; i < 128; i++) m.push_back(8'($urandom));
        run_msg(m, 0);
        m = {}; for (int i = 0; i < 130; i++) m.push_back(8'($urandom));
        run_msg(m, 1);

        for (int t = 0; t < 14; t++) begin
            m = {};
            for (int i = 0; i < int'($urandom_range(1, 200)); i++) m.push_back(8'($urandom));
            run_msg(m, ($urandom % 2 == 0) ? 1 : 2);
        end
        for (int r = 55; r <= 65; r++) begin
            m = {};
            for (int i = 0; i < r; i++) m.push_back(8'($urandom));
            run_msg(m, 2);
        end

        // Abort a partial message with reset, then confirm a clean restart.
        acc = 0;
        while (acc < 30) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            blk_ready = 1'b1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_blk_valid", 512'(blk_valid), 512'd0);
        check_val("abort_in_ready", 512'(in_ready), 512'd0);
        check_val("abort_blk_data", blk_data, 512'd0);
        rst = 1'b0;
        @(negedge clk);
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Producer side of the SHA-256 core's 512-bit block interface.
- Accepts a message as a byte stream with a valid/ready handshake.
- Applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit big-endian bit length.
- Emits one or more 512-bit blocks, each with valid/ready and a last-block flag, so the compression core never needs the message length up front.

Parameters:
- LEN_W, 64, width of the internal bit-length counter. Values below 64 are zero-extended into the length field. The counter wraps modulo 2^LEN_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is a valid message byte.
- in_ready  output  1  padder can accept a byte this cycle.
- in_data  input  8  message byte; the first byte maps to blk_data[511:504].
- in_last  input  1  qualifies the final byte of a message. Zero-length messages are not supported.
- blk_valid  output  1  blk_data holds a complete padded block.
- blk_ready  input  1  downstream core accepts the block.
- blk_data  output  512  block, big-endian: byte k at bits [511-8k : 504-8k].
- blk_last  output  1  this is the final block of the message.

Behaviour:
- Reset (async assert, sync release) sets:
  - in_ready=0 while rst is high; in_ready=1 the first cycle after release.
  - blk_valid=0, blk_last=0, blk_data=0.
  - byte_cnt=0, bit_len=0, pend_extra=0, state=FILL.
- Reset mid-operation discards the partial message and any held block; no block is emitted.
- Byte accept: a byte is accepted when in_valid && in_ready. Each accept writes byte position byte_cnt, increments byte_cnt (7-bit, range 0..64) and adds 8 to bit_len.
- FILL state:
  - in_ready=1, blk_valid=0.
  - On accept with in_last=0 and new byte_cnt<64: stay in FILL.
  - On accept with in_last=0 and new byte_cnt=64: go to EMIT, blk_last=0, byte_cnt=0.
  - On accept with in_last=1, let r = new byte_cnt (1..64) and L = bit_len including this byte:
    - r<=55: write 0x80 at byte r, zero bytes r+1..55, write L into bytes 56..63. Go to EMIT with blk_last=1.
    - 56<=r<=63: write 0x80 at byte r, zero the rest. Go to EMIT with blk_last=0, pend_extra=1, extra_marker=0.
    - r=64: block is data only. Go to EMIT with blk_last=0, pend_extra=1, extra_marker=1.
- EMIT state:
  - in_ready=0, blk_valid=1.
  - blk_data and blk_last stay stable until blk_ready.
  - On handshake with pend_extra=0:
    - If blk_last=1: clear bit_len and byte_cnt.
    - Go to FILL next cycle.
  - On handshake with pend_extra=1:
    - Next cycle blk_data = extra block: byte0=0x80 if extra_marker else 0x00, bytes 1..55 zero, bytes 56..63 = L.
    - blk_last=1, pend_extra=0, stay in EMIT.
    - No idle cycle between the two blocks.
- Latency:
  - blk_valid rises the cycle after the accept of byte 64 or of the last byte.
  - Throughput: 64 bytes per 65 cycles minimum for multi-block messages with blk_ready tied high.
- Unused byte positions are always driven zero, never stale data from an earlier message.
- bit_len overflow wraps silently; no error output.
- blk_ready is ignored while blk_valid=0.
- in_data and in_last are ignored unless in_valid && in_ready.

Test Plan:
- "abc" (0x61,0x62,0x63, in_last on 0x63), blk_ready=1 -> one block, blk_last=1, word0=0x61626380, words1..14=0, word15=0x00000018, blk_valid high exactly 1 cycle.
- 55 bytes of 0x00 -> one block, byte55=0x80, length field=0x1B8, blk_last=1.
- 56 bytes of 0x00 -> block A: byte56=0x80, rest zero, blk_last=0. Block B, on the next cycle: all zero except length=0x1C0, blk_last=1.
- 64 bytes 0x00..0x3F -> block A = data verbatim, blk_last=0. Block B: byte0=0x80, length=0x200, blk_last=1. Then a 128-byte message gives blocks with last flags 0,0,1 and final length 0x400.
- Backpressure: blk_ready held low 5 cycles during EMIT -> blk_data/blk_last stable, in_ready=0 throughout, no byte lost when in_valid is held high.
- Assert rst after 30 bytes of a message, release, then send "abc" -> no block from the aborted message; output identical to the first scenario (length 0x18).
